// File: rtl/cache_ctrl_burst_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types for the burst cache controller: the controller state encoding
// and the bus direction constants used for PRW and SysRW.
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SYS_RD,
    READDATA,
    WRITEHIT,
    SYS_WR,
    WRITEDATA
  } state_e;

  // Direction encoding shared by the CPU port (PRW) and the system bus (SysRW).
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/cache_ctrl_burst_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_burst_if
// Bundles the CPU request, the tag-compare inputs and every control output of
// the controller.
//   slave  : the controller (samples requests, drives array/bus controls)
//   master : the surrounding CPU / cache datapath
// WW is the WordSel width and must equal max(1, $clog2(LINE_WORDS)).
// -----------------------------------------------------------------------------
interface cache_ctrl_burst_if #(
  parameter int WW = 2
);
  logic          PStrobe;
  logic          PRW;
  logic          Match;
  logic          Valid;
  logic          PReady;
  logic          Write;
  logic          CacheDataSelect;
  logic          PDataSelect;
  logic          SysDataOE;
  logic          PDataOE;
  logic          SysStrobe;
  logic          SysRW;
  logic [WW-1:0] WordSel;
  logic          SetValid;

  modport slave (
    input  PStrobe, PRW, Match, Valid,
    output PReady, Write, CacheDataSelect, PDataSelect, SysDataOE, PDataOE,
           SysStrobe, SysRW, WordSel, SetValid
  );

  modport master (
    output PStrobe, PRW, Match, Valid,
    input  PReady, Write, CacheDataSelect, PDataSelect, SysDataOE, PDataOE,
           SysStrobe, SysRW, WordSel, SetValid
  );
endinterface

// File: rtl/cache_ctrl_burst_wait_ctr.sv
// -----------------------------------------------------------------------------
// cache_wait_ctr
// Wait-state down-counter. Load has priority and takes LoadValue; otherwise the
// count decrements and parks at zero. Carry flags the completing bus cycle.
//   Clk, Reset : clock, synchronous active-high reset
//   Load       : reload the count with LoadValue
//   LoadValue  : reload value (WAIT_STATES-1 in the controller)
//   Carry      : count == 0
// -----------------------------------------------------------------------------
module cache_wait_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic             Carry
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (Load) begin
      count_d = LoadValue;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: reset is tested inside the clocked block, so it is synchronous and
  // only takes effect on a rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples its pre-edge inputs regardless of statement order.
      count_q <= count_d;
    end
  end

  assign Carry = (count_q == '0);

endmodule

// File: rtl/cache_ctrl_burst.sv
// -----------------------------------------------------------------------------
// cache_ctrl_burst
// Direct-mapped, write-through cache controller with configurable bus wait
// states, multi-word line refill and selectable write-miss policy.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of cache_ctrl_burst_if (CPU request, tag compare
//                inputs, array / mux / bus-enable controls, refill WordSel)
// Parameters: WAIT_STATES (1..15) bus cycles per beat, LINE_WORDS (power of
// two, 1..16) words per refill, WRITE_ALLOCATE (0/1) write-miss policy.
// -----------------------------------------------------------------------------
import cache_ctrl_pkg::*;

module cache_ctrl_burst #(
  parameter int WAIT_STATES    = 2,
  parameter int LINE_WORDS     = 4,
  parameter int WRITE_ALLOCATE = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  cache_ctrl_burst_if.slave   bus
);

  localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW = $clog2(WAIT_STATES + 1);

  // A beat spans WAIT_STATES cycles, so the counter restarts one below that
  // and the beat completes on the cycle it reads zero.
  localparam logic [CW-1:0] RELOAD    = CW'(WAIT_STATES - 1);
  localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);

  state_e          state_q, state_d;
  logic [WW-1:0]   beat_q, beat_d;
  logic            op_q, op_d;
  logic            ctr_load;
  logic            ctr_carry;

  cache_wait_ctr #(.WIDTH(CW)) u_wait_ctr (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (ctr_load),
    .LoadValue (RELOAD),
    .Carry     (ctr_carry)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= READ;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    beat_d              = beat_q;
    op_d                = op_q;
    ctr_load            = 1'b0;
    bus.PReady          = 1'b0;
    bus.Write           = 1'b0;
    bus.CacheDataSelect = 1'b0;
    bus.PDataSelect     = 1'b0;
    bus.SysDataOE       = 1'b0;
    bus.PDataOE         = 1'b0;
    bus.SysStrobe       = 1'b0;
    bus.SysRW           = READ;
    bus.WordSel         = '0;
    bus.SetValid        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.PStrobe) begin
          op_d    = bus.PRW;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (bus.Match && bus.Valid) begin
          if (op_q == READ) begin
            // Read hit completes in the lookup cycle itself.
            bus.PReady      = 1'b1;
            bus.PDataSelect = 1'b1;
            bus.PDataOE     = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = WRITEHIT;
          end
        end else begin
          ctr_load = 1'b1;
          beat_d   = '0;
          if (op_q == READ || WRITE_ALLOCATE != 0) begin
            state_d = SYS_RD;
          end else begin
            state_d = SYS_WR;
          end
        end
      end

      SYS_RD: begin
        bus.SysStrobe = 1'b1;
        bus.SysRW     = READ;
        bus.WordSel   = beat_q;
        if (ctr_carry) begin
          bus.Write           = 1'b1;
          bus.CacheDataSelect = 1'b0;
          if (beat_q == LAST_BEAT) begin
            // Line becomes valid together with its last word.
            bus.SetValid = 1'b1;
            state_d      = (op_q == WRITE) ? WRITEHIT : READDATA;
          end else begin
            beat_d   = beat_q + WW'(1);
            ctr_load = 1'b1;
          end
        end
      end

      READDATA: begin
        bus.PReady      = 1'b1;
        bus.PDataSelect = 1'b1;
        bus.PDataOE     = 1'b1;
        state_d         = IDLE;
      end

      WRITEHIT: begin
        bus.Write           = 1'b1;
        bus.CacheDataSelect = 1'b1;
        ctr_load            = 1'b1;
        state_d             = SYS_WR;
      end

      SYS_WR: begin
        bus.SysStrobe = 1'b1;
        bus.SysRW     = WRITE;
        bus.SysDataOE = 1'b1;
        if (ctr_carry) begin
          state_d = WRITEDATA;
        end
      end

      WRITEDATA: begin
        bus.PReady = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_burst
// Three controllers share one stimulus: dut_a (defaults), dut_b
// (WAIT_STATES=3) and dut_c (WRITE_ALLOCATE=1). Each scenario resets, issues a
// request in T0 and compares a packed output vector every cycle against
// hand-written cycle tables.
// Vector bit order: {PReady, Write, CacheDataSelect, PDataSelect, SysDataOE,
//                    PDataOE, SysStrobe, SysRW, SetValid, WordSel[1:0]}
// -----------------------------------------------------------------------------
module tb_cache_ctrl_burst;

  localparam int S_RD_HIT       = 0;
  localparam int S_RD_HIT_HOLD  = 1;
  localparam int S_RD_MISS      = 2;
  localparam int S_RD_MISS_HOLD = 3;
  localparam int S_WR_HIT3      = 4;
  localparam int S_WR_MISS_NA   = 5;
  localparam int S_WR_MISS_WA   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pstrobe = 1'b0;
  logic prw = 1'b0;
  logic match = 1'b0;
  logic valid = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_ctrl_burst_if #(.WW(2)) if_a ();
  cache_ctrl_burst_if #(.WW(2)) if_b ();
  cache_ctrl_burst_if #(.WW(2)) if_c ();

  assign if_a.PStrobe = pstrobe;  assign if_a.PRW = prw;
  assign if_a.Match   = match;    assign if_a.Valid = valid;
  assign if_b.PStrobe = pstrobe;  assign if_b.PRW = prw;
  assign if_b.Match   = match;    assign if_b.Valid = valid;
  assign if_c.PStrobe = pstrobe;  assign if_c.PRW = prw;
  assign if_c.Match   = match;    assign if_c.Valid = valid;

  cache_ctrl_burst #(.WAIT_STATES(2), .LINE_WORDS(4), .WRITE_ALLOCATE(0))
    dut_a (.Clk(clk), .Reset(rst), .bus(if_a));
  cache_ctrl_burst #(.WAIT_STATES(3), .LINE_WORDS(4), .WRITE_ALLOCATE(0))
    dut_b (.Clk(clk), .Reset(rst), .bus(if_b));
  cache_ctrl_burst #(.WAIT_STATES(2), .LINE_WORDS(4), .WRITE_ALLOCATE(1))
    dut_c (.Clk(clk), .Reset(rst), .bus(if_c));

  logic [10:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.PReady, if_a.Write, if_a.CacheDataSelect, if_a.PDataSelect,
                  if_a.SysDataOE, if_a.PDataOE, if_a.SysStrobe, if_a.SysRW,
                  if_a.SetValid, if_a.WordSel};
  assign obs_b = {if_b.PReady, if_b.Write, if_b.CacheDataSelect, if_b.PDataSelect,
                  if_b.SysDataOE, if_b.PDataOE, if_b.SysStrobe, if_b.SysRW,
                  if_b.SetValid, if_b.WordSel};
  assign obs_c = {if_c.PReady, if_c.Write, if_c.CacheDataSelect, if_c.PDataSelect,
                  if_c.SysDataOE, if_c.PDataOE, if_c.SysStrobe, if_c.SysRW,
                  if_c.SetValid, if_c.WordSel};

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Refill section of a read miss (or allocating write miss) with defaults:
  // SysStrobe T2..T9, WordSel 0,0,1,1,2,2,3,3, Write on T3/T5/T7/T9,
  // SetValid on T9.
  function automatic logic [10:0] refill_vec(input int t);
    logic [10:0] v;
    case (t)
      2:       v = 11'b000000100_00;
      3:       v = 11'b010000100_00;
      4:       v = 11'b000000100_01;
      5:       v = 11'b010000100_01;
      6:       v = 11'b000000100_10;
      7:       v = 11'b010000100_10;
      8:       v = 11'b000000100_11;
      9:       v = 11'b010000101_11;
      default: v = 11'b000000000_00;
    endcase
    return v;
  endfunction

  function automatic logic [10:0] exp_vec(input int scn, input int t);
    logic [10:0] rd_done;
    logic [10:0] wr_hit;
    logic [10:0] sys_wr;
    logic [10:0] wr_done;
    logic [10:0] v;
    rd_done = 11'b100101000_00;  // PReady, PDataSelect, PDataOE
    wr_hit  = 11'b011000000_00;  // Write, CacheDataSelect
    sys_wr  = 11'b000010110_00;  // SysDataOE, SysStrobe, SysRW
    wr_done = 11'b100000000_00;  // PReady
    v = '0;
    case (scn)
      S_RD_HIT:       if (t == 1) v = rd_done;
      S_RD_HIT_HOLD:  if (t == 1 || t == 3 || t == 5) v = rd_done;
      S_RD_MISS:      v = (t == 10) ? rd_done : refill_vec(t);
      S_RD_MISS_HOLD: begin
        // Re-accepted in T11, lookup miss in T12, new refill starts T13.
        if (t == 10)      v = rd_done;
        else if (t == 13) v = 11'b000000100_00;
        else              v = refill_vec(t);
      end
      S_WR_HIT3: begin
        if (t == 2)               v = wr_hit;
        else if (t >= 3 && t <= 5) v = sys_wr;
        else if (t == 6)          v = wr_done;
      end
      S_WR_MISS_NA: begin
        if (t == 2 || t == 3) v = sys_wr;
        else if (t == 4)      v = wr_done;
      end
      S_WR_MISS_WA: begin
        if (t == 10)                 v = wr_hit;
        else if (t == 11 || t == 12) v = sys_wr;
        else if (t == 13)            v = wr_done;
        else                         v = refill_vec(t);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pstrobe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_case(input string name, input int scn, input int dut_sel,
                          input logic rw, input logic hit, input int ncyc,
                          input logic hold);
    logic [10:0] got;
    do_reset();
    pstrobe = 1'b1;
    prw     = rw;
    match   = hit;
    valid   = hit;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      case (dut_sel)
        1:       got = obs_b;
        2:       got = obs_c;
        default: got = obs_a;
      endcase
      check($sformatf("%s T%0d", name, t), got, exp_vec(scn, t));
      @(posedge clk);
      #1;
      if (!hold) pstrobe = 1'b0;
    end
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("reset a", obs_a, 11'b0);
    check("reset b", obs_b, 11'b0);
    check("reset c", obs_c, 11'b0);

    run_case("rd_hit",       S_RD_HIT,       0, 1'b0, 1'b1, 4,  1'b0);
    run_case("rd_miss",      S_RD_MISS,      0, 1'b0, 1'b0, 12, 1'b0);
    run_case("wr_hit_ws3",   S_WR_HIT3,      1, 1'b1, 1'b1, 8,  1'b0);
    run_case("wr_miss_na",   S_WR_MISS_NA,   0, 1'b1, 1'b0, 6,  1'b0);
    run_case("wr_miss_wa",   S_WR_MISS_WA,   2, 1'b1, 1'b0, 15, 1'b0);
    run_case("rd_hit_hold",  S_RD_HIT_HOLD,  0, 1'b0, 1'b1, 7,  1'b1);
    run_case("rd_miss_hold", S_RD_MISS_HOLD, 0, 1'b0, 1'b0, 14, 1'b1);

    // Reset during refill beat 2 (T6), then a clean read hit.
    do_reset();
    pstrobe = 1'b1;
    prw     = 1'b0;
    match   = 1'b0;
    valid   = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      check($sformatf("abort T%0d", t), obs_a, exp_vec(S_RD_MISS, t));
      if (t == 6) rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pstrobe = 1'b0;
    end
    @(negedge clk);
    check("abort T7 a", obs_a, 11'b0);
    check("abort T7 c", obs_c, 11'b0);
    @(posedge clk);
    #1;
    pstrobe = 1'b1;
    match   = 1'b1;
    valid   = 1'b1;
    @(negedge clk);
    check("abort T8", obs_a, 11'b0);
    @(posedge clk);
    #1;
    pstrobe = 1'b0;
    @(negedge clk);
    check("abort T9 hit", obs_a, 11'b100101000_00);
    for (int t = 10; t <= 12; t++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("abort T%0d", t), obs_a, 11'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
